// File: rtl/param_seq_multiplier.sv
// -----------------------------------------------------------------------------
// param_seq_multiplier
//   Radix-2 shift-add sequential multiplier with unsigned or two's-complement
//   operands. The operands are captured as magnitudes and the product sign is
//   applied in a single fix-up cycle. Fixed latency is WIDTH+1 edges from the
//   capture edge to Done.
//
//   Optional feature macro: MULT_EARLY_TERM_EN
//     When defined, CALC ends as soon as the remaining multiplier bits are all
//     zero (minimum of one iteration). FIX then re-aligns the partially shifted
//     accumulator, so the product is the same as in fixed-latency mode.
//
// Ports
//   Clk     in   clock, rising edge
//   Rst_n   in   asynchronous active-low reset
//   St      in   start request (level, sampled in IDLE only)
//   Sgn     in   1 = two's-complement operands, 0 = unsigned
//   Mplier  in   multiplier   [WIDTH-1:0]
//   Mcand   in   multiplicand [WIDTH-1:0]
//   Busy    out  high in CALC and FIX
//   Done    out  high in DONE
//   Result  out  registered product [2*WIDTH-1:0]
//
// state | meaning
// IDLE  | waiting for St; Result holds the last product
// CALC  | one add/shift iteration per cycle
// FIX   | sign fix-up, Result written
// DONE  | Done held until St is seen low
// -----------------------------------------------------------------------------
module param_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 St,
  input  logic                 Sgn,
  input  logic [WIDTH-1:0]     Mplier,
  input  logic [WIDTH-1:0]     Mcand,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH:0]     acc_q;      // {carry, partial product, remaining multiplier}
  logic [WIDTH-1:0]     mcand_q;
  logic                 sign_q;
  logic [CW-1:0]        cnt_q;      // iterations still to run
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   result_q;
`ifdef MULT_EARLY_TERM_EN
  logic [WIDTH-1:0]     mrem_q;     // multiplier bits not yet consumed
`endif

  logic [WIDTH-1:0]     mplier_mag;
  logic [WIDTH-1:0]     mcand_mag;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH:0]     acc_d;
  logic                 last_iter;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   fix_val;

  always_comb begin
    mplier_mag = (Sgn && Mplier[WIDTH-1]) ? (~Mplier + WIDTH'(1)) : Mplier;
    mcand_mag  = (Sgn && Mcand[WIDTH-1])  ? (~Mcand  + WIDTH'(1)) : Mcand;

    sum_d = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum_d, acc_q[WIDTH-1:0]} >> 1;

`ifdef MULT_EARLY_TERM_EN
    last_iter = (cnt_q == CW'(1)) || ((mrem_q >> 1) == '0);
    // Skipped iterations would only have shifted right, so apply them at once.
    prod      = acc_q[2*WIDTH-1:0] >> cnt_q;
`else
    last_iter = (cnt_q == CW'(1));
    prod      = acc_q[2*WIDTH-1:0];
`endif

    fix_val = sign_q ? ((2*WIDTH)'(0) - prod) : prod;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MULT_EARLY_TERM_EN
      mrem_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (St) begin
            acc_q   <= {(WIDTH+1)'(0), mplier_mag};
            mcand_q <= mcand_mag;
            sign_q  <= Sgn & (Mplier[WIDTH-1] ^ Mcand[WIDTH-1]);
            cnt_q   <= CW'(WIDTH);
`ifdef MULT_EARLY_TERM_EN
            mrem_q  <= mplier_mag;
`endif
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
`ifdef MULT_EARLY_TERM_EN
          mrem_q <= mrem_q >> 1;
`endif
          if (last_iter) state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_val;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (!St) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_param_seq_multiplier.sv
module tb_param_seq_multiplier;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        St = 1'b0;
  logic        Sgn = 1'b0;
  logic [7:0]  Mplier = '0;
  logic [7:0]  Mcand = '0;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;

  param_seq_multiplier #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .St(St), .Sgn(Sgn),
    .Mplier(Mplier), .Mcand(Mcand),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        sgn;
    logic [7:0]  mp;
    logic [7:0]  mc;
    logic [15:0] res;
    bit          hold;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic sgn, input logic [7:0] mp);
`ifdef MULT_EARLY_TERM_EN
    logic [7:0] mag;
    int n;
    mag = (sgn && mp[7]) ? (~mp + 8'd1) : mp;
    n = 0;
    for (int i = 0; i < 8; i++) if (mag[i]) n = i + 1;
    if (n < 1) n = 1;
    return n + 1;
`else
    return 9;
`endif
  endfunction

  task automatic run_op(input logic sgn, input logic [7:0] mp, input logic [7:0] mc,
                        input logic [15:0] res, input bit hold, input string name);
    exp_t e;
    int lat;
    int busy_cnt;
    St = 1'b1; Sgn = sgn; Mplier = mp; Mcand = mc;
    @(posedge Clk);
    sb.push_back('{res: res, lat: exp_lat(sgn, mp)});
    #1;
    // operands and St changing during CALC must be ignored
    Mplier = 8'($urandom); Mcand = 8'($urandom); Sgn = 1'($urandom);
    if (!hold) St = 1'b0;
    busy_cnt = Busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (Done) begin lat = k; break; end
      if (Busy) busy_cnt++;
    end
    e = sb.pop_front();
    chk({name, " latency"}, lat, e.lat);
    chk({name, " busy_cycles"}, busy_cnt, e.lat);
    chk({name, " result"}, Result, e.res);
    if (hold) begin
      repeat (3) @(posedge Clk);
      #1;
      chk({name, " held_done"}, Done, 1);
      chk({name, " held_busy"}, Busy, 0);
      chk({name, " held_result"}, Result, e.res);
    end
    St = 1'b0;
    @(posedge Clk); #1;
    chk({name, " idle_done"}, Done, 0);
    chk({name, " idle_result"}, Result, e.res);
  endtask

  vec_t vecs[10];

  initial begin
    logic [7:0] rmp, rmc;
    logic       rsg;
    logic [15:0] rexp;

    vecs[0] = '{1'b0, 8'd10,  8'd5,   16'd50,   1'b0};
    vecs[1] = '{1'b0, 8'd64,  8'd72,  16'h1200, 1'b1};
    vecs[2] = '{1'b1, 8'hFD,  8'd7,   16'hFFEB, 1'b0};
    vecs[3] = '{1'b1, 8'h80,  8'h80,  16'h4000, 1'b1};
    vecs[4] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b0};
    vecs[5] = '{1'b1, 8'hFF,  8'hFF,  16'h0001, 1'b0};
    vecs[6] = '{1'b1, 8'h7F,  8'h80,  16'hC080, 1'b0};
    vecs[7] = '{1'b0, 8'd1,   8'd200, 16'd200,  1'b0};
    vecs[8] = '{1'b0, 8'd0,   8'hAB,  16'd0,    1'b0};
    vecs[9] = '{1'b1, 8'd1,   8'h80,  16'hFF80, 1'b1};

    #1;
    chk("reset busy", Busy, 0);
    chk("reset done", Done, 0);
    chk("reset result", Result, 0);
    #11 Rst_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sgn, vecs[i].mp, vecs[i].mc, vecs[i].res, vecs[i].hold,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rmp = 8'($urandom); rmc = 8'($urandom); rsg = 1'($urandom);
      if (rsg) rexp = 16'($signed({{8{rmp[7]}}, rmp}) * $signed({{8{rmc[7]}}, rmc}));
      else     rexp = 16'({8'd0, rmp} * {8'd0, rmc});
      run_op(rsg, rmp, rmc, rexp, 1'($urandom), $sformatf("rnd%0d", i));
    end

    // reset four cycles after capture aborts the operation asynchronously
    St = 1'b1; Sgn = 1'b0; Mplier = 8'd200; Mcand = 8'd3;
    @(posedge Clk);
    sb.push_back('{res: 16'd600, lat: exp_lat(1'b0, 8'd200)});
    #1 St = 1'b0;
    repeat (4) @(posedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    chk("midreset busy", Busy, 0);
    chk("midreset done", Done, 0);
    chk("midreset result", Result, 0);
    void'(sb.pop_front());
    #2 Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("postreset idle_busy", Busy, 0);
    chk("postreset idle_done", Done, 0);
    run_op(1'b1, 8'hF6, 8'd12, 16'hFF88, 1'b0, "postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be legal for any value from 2 to 32.
REQ-002 Port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port St, input, 1 bit: start request, level-sensitive, sampled only in IDLE.
REQ-005 Port Sgn, input, 1 bit: operand mode, 1 = two's-complement, 0 = unsigned; captured with the operands.
REQ-006 Port Mplier, input, WIDTH bits: multiplier operand.
REQ-007 Port Mcand, input, WIDTH bits: multiplicand operand.
REQ-008 Port Busy, output, 1 bit: high while in CALC or FIX.
REQ-009 Port Done, output, 1 bit: high while in DONE.
REQ-010 Port Result, output, 2*WIDTH bits: product, registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-012 IDLE with St=1 at an edge (the capture edge) SHALL capture Mplier, Mcand and Sgn, then enter CALC.
REQ-013 When Sgn=1 at capture, the operands SHALL be stored as magnitudes and the sign flag SHALL be stored as the XOR of the two operand MSBs.
REQ-014 Each CALC cycle SHALL add the multiplicand magnitude to the partial product when the multiplier LSB is 1, then shift right by one bit; iteration is radix-2 shift-add.
REQ-015 CALC SHALL run exactly WIDTH iterations and then enter FIX (the MULT_EARLY_TERM_EN exception is in REQ-026).
REQ-016 FIX SHALL write Result, two's-complement negated when the sign flag is 1, and then enter DONE.
REQ-017 The accumulator SHALL be 2*WIDTH+1 bits so the add carry is never lost.
REQ-018 The full product SHALL fit in Result for all inputs (e.g. -2^(WIDTH-1) squared), so no overflow indication is required.
REQ-019 Latency: Done SHALL rise WIDTH+1 edges after the capture edge; with WIDTH=8 this is 9 edges.
REQ-020 DONE SHALL hold Done=1 and Result stable until St=0 is sampled, then return to IDLE.
REQ-021 An St held high through DONE SHALL NOT trigger a new operation; one operation is started per St assertion.
REQ-022 In CALC and FIX, changes on St, Sgn, Mplier and Mcand SHALL be ignored.
REQ-023 Result SHALL keep the last product through IDLE and until the next FIX overwrites it.

Reset
REQ-024 Rst_n=0 SHALL immediately force: state IDLE, Busy=0, Done=0, Result=0, and all internal registers cleared.
REQ-025 Reset asserted mid-CALC or mid-FIX SHALL abort the operation with no partial Result visible; after release the block SHALL wait in IDLE for a new St.

Configuration
REQ-026 With macro MULT_EARLY_TERM_EN defined, CALC SHALL move to FIX as soon as the remaining shifted multiplier bits are all zero, with a minimum of 1 iteration.
- Done latency SHALL then be N+1 edges, where N = max(1, index of the highest set bit of |Mplier| + 1).
- Result value SHALL be identical to the fixed-latency mode.
REQ-027 With MULT_EARLY_TERM_EN undefined, CALC SHALL always run WIDTH iterations and no early-termination logic SHALL be present.

Verification (WIDTH=8)
REQ-028 Unsigned basic: Sgn=0, Mplier=10, Mcand=5, St=1 -> Done rises 9 edges after capture, Result=50; Busy high for 9 cycles.
REQ-029 Operand change and held St: after the first product, drop St, then Mplier=64, Mcand=72, St=1 -> Result=4608 (0x1200); operands changed mid-CALC are ignored; St held high at DONE does not restart.
REQ-030 Signed: Sgn=1, Mplier=-3 (0xFD), Mcand=7 -> Result=0xFFEB (-21).
REQ-031 Extremes: Sgn=1, Mplier=Mcand=0x80 -> Result=0x4000; Sgn=0, Mplier=Mcand=0xFF -> Result=0xFE01.
REQ-032 Reset mid-operation: Rst_n=0 four cycles after capture -> Busy, Done and Result go to 0 without a clock edge; a new St then yields the correct product.
REQ-033 Early termination, with MULT_EARLY_TERM_EN defined: Mplier=1, Mcand=200 -> Done 2 edges after capture, Result=200; Mplier=0 -> Result=0 after 2 edges.
